// File: rtl/bcd_gray_pkg.sv
// Shared definitions for the BCD-to-Gray sequencing controller:
// state encodings, digit width and the largest legal BCD digit.
package bcd_gray_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CONV = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_CONV = S_CONV,
    ST_DONE = S_DONE
  } state_t;

endpackage

// File: rtl/bcd_to_gray.sv
// Single-digit converter: 4-bit binary/BCD digit to 4-bit reflected Gray code.
// Purely combinational; shared across digits by the sequencing controller.
module bcd_to_gray (
  input  logic [3:0] bcd,
  output logic [3:0] gray
);

  assign gray = bcd ^ {1'b0, bcd[3:1]};

endmodule

// File: rtl/bcd_gray_seq_ctrl.sv
// Converts a packed DIGITS-digit BCD word to packed Gray, one digit per clock,
// through a single bcd_to_gray instance. Define BCD_GRAY_ERR_CHECK_EN to flag
// and zero out digits above 9; otherwise such digits convert raw.
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready high, last result still on outputs
// CONV  | one digit converted per clock, low digit first
// DONE  | result held with out_valid high until out_ready
module bcd_gray_seq_ctrl
  import bcd_gray_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIGIT_W*DIGITS-1:0] in_bcd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] out_gray,
  output logic                      out_err,
  output logic                      busy
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_t             state, state_nxt;
  logic               load, step, ack;
  logic [W-1:0]       sr;
  logic [W-1:0]       gray_q;
  logic               err_q;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] conv_in, conv_out, field;
  logic               digit_err;

  assign conv_in = sr[DIGIT_W-1:0];

  bcd_to_gray u_conv (
    .bcd  (conv_in),
    .gray (conv_out)
  );

`ifdef BCD_GRAY_ERR_CHECK_EN
  assign digit_err = (conv_in > BCD_MAX);
  assign field     = digit_err ? '0 : conv_out;
`else
  assign digit_err = 1'b0;
  assign field     = conv_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // in_ready is gated by rst_n so it stays low for the whole reset pulse.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    ack       = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = rst_n;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = ST_CONV;
        end
      end
      ST_CONV: begin
        busy = 1'b1;
        step = 1'b1;
        if (idx == IDX_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          ack       = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr     <= '0;
      gray_q <= '0;
      err_q  <= 1'b0;
      idx    <= '0;
    end else if (load) begin
      sr     <= in_bcd;
      gray_q <= '0;
      err_q  <= 1'b0;
      idx    <= '0;
    end else if (step) begin
      sr    <= sr >> DIGIT_W;
      err_q <= err_q | digit_err;
      idx   <= idx + 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
        if (idx == IDX_W'(k)) gray_q[k*DIGIT_W +: DIGIT_W] <= field;
      end
    end else if (ack) begin
      idx <= '0;
    end
  end

  assign out_gray = gray_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_bcd_gray_seq_ctrl.sv
// Directed bench for bcd_gray_seq_ctrl with DIGITS=4; expected Gray words are
// hand-computed. Honours BCD_GRAY_ERR_CHECK_EN for the invalid-digit case.
module tb_bcd_gray_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_gray;
  logic        out_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_gray_seq_ctrl #(.DIGITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bcd    (in_bcd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_err   (out_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic start_word(input logic [15:0] bcd, input string tag);
    check({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_bcd   = bcd;
    step_clk();
    in_valid = 1'b0;
    in_bcd   = 16'hFFFF;
    check({tag, " busy in CONV"}, 32'(busy), 32'd1);
    check({tag, " in_ready in CONV"}, 32'(in_ready), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      step_clk();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
  endtask

  task automatic run_word(input logic [15:0] bcd, input logic [15:0] exp_gray,
                          input logic exp_err, input string tag);
    out_ready = 1'b1;
    start_word(bcd, tag);
    wait_valid(tag);
    check({tag, " out_gray"}, 32'(out_gray), 32'(exp_gray));
    check({tag, " out_err"}, 32'(out_err), 32'(exp_err));
    step_clk();
    check({tag, " out_valid after ack"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready after ack"}, 32'(in_ready), 32'd1);
    check({tag, " busy after ack"}, 32'(busy), 32'd0);
    check({tag, " out_gray held in IDLE"}, 32'(out_gray), 32'(exp_gray));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    out_ready = 1'b1;
    #2;
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset out_gray", 32'(out_gray), 32'd0);
    check("reset out_err", 32'(out_err), 32'd0);
    #10 rst_n = 1'b1;
    #1;
    check("post-reset in_ready", 32'(in_ready), 32'd1);
    step_clk();

    run_word(16'h1234, 16'h1326, 1'b0, "basic");
    run_word(16'h9870, 16'hDC40, 1'b0, "high");
`ifdef BCD_GRAY_ERR_CHECK_EN
    run_word(16'h00A5, 16'h0007, 1'b1, "invalid");
`else
    run_word(16'h00A5, 16'h00F7, 1'b0, "invalid");
`endif
    run_word(16'h0000, 16'h0000, 1'b0, "zero");

    // backpressure: hold DONE for 5 cycles and poke in_valid meanwhile
    out_ready = 1'b0;
    start_word(16'h1234, "bp");
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 1);
      in_bcd   = 16'h5555;
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp out_gray", 32'(out_gray), 32'h1326);
      check("bp out_err", 32'(out_err), 32'd0);
      step_clk();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step_clk();
    check("bp out_valid after ack", 32'(out_valid), 32'd0);
    check("bp in_ready after ack", 32'(in_ready), 32'd1);
    check("bp out_gray after ack", 32'(out_gray), 32'h1326);
    run_word(16'h5555, 16'h7777, 1'b0, "bp-next");

    // reset during the second CONV cycle
    start_word(16'h1234, "rst");
    step_clk();
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready", 32'(in_ready), 32'd0);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_gray", 32'(out_gray), 32'd0);
    check("rst out_err", 32'(out_err), 32'd0);
    #3 rst_n = 1'b1;
    #1;
    check("rst release in_ready", 32'(in_ready), 32'd1);
    run_word(16'h0001, 16'h0001, 1'b0, "after-rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_gray_seq_ctrl.md
Name: bcd_gray_seq_ctrl

Overview:
Sequencing controller that converts a packed multi-digit BCD word to packed Gray code through one shared bcd_to_gray converter instance, one digit per clock.
- Valid/ready handshake on both the input and output sides.
- Sits between a BCD source (counter or display path) and Gray-coded consumers, so a single combinational converter is reused instead of replicated per digit.

Parameters:
DIGITS, 4, number of BCD digits per word (minimum 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  source presents a word on in_bcd
in_ready  output  1  controller can accept a word
in_bcd  input  4*DIGITS  packed BCD word; digit k = in_bcd[4k+3:4k]
out_valid  output  1  out_gray/out_err hold a finished result
out_ready  input  1  consumer accepts the result
out_gray  output  4*DIGITS  packed Gray word; field k = Gray of digit k
out_err  output  1  at least one input digit was greater than 9
busy  output  1  high in CONV or DONE

Behaviour:
- Reset (asynchronous, rst_n low): state=IDLE, in_ready=0 while asserted, out_valid=0, out_gray=0, out_err=0, busy=0, digit index=0, shift register=0. Reset takes effect immediately, including mid-CONV or mid-DONE; the partial result is discarded.
- States: IDLE, CONV, DONE, encoded as 2-bit localparams.
- IDLE:
  - in_ready=1, busy=0.
  - On a clock edge where in_valid && in_ready: capture in_bcd into the shift register, clear the out_gray accumulator and out_err, set idx=0, go to CONV.
- CONV:
  - in_ready=0, busy=1.
  - The converter input is the low nibble of the shift register.
  - Each edge: write the converter output into field idx of the out_gray register; OR the error flag (see Optional Feature); shift the register right by 4; increment idx.
  - When idx==DIGITS-1 on that edge, go to DONE.
  - Exactly DIGITS cycles are spent in CONV. DIGITS=1 gives one CONV cycle.
- DONE:
  - out_valid=1, in_ready=0, busy=1.
  - out_gray and out_err stay stable until out_valid && out_ready on an edge, then go to IDLE with out_valid=0.
  - out_gray and out_err keep their last value in IDLE until the next acceptance.
- Latency: out_valid is first seen high DIGITS cycles after the acceptance edge. Throughput is at most one word per DIGITS+2 cycles; there is no back-to-back acceptance.
- in_valid is ignored outside IDLE, and in_bcd changes after acceptance have no effect.
- Gray arithmetic is in the sub-module: gray = b ^ (b >> 1) per 4-bit digit. No carries between digits.
- idx width: clog2(DIGITS), minimum 1 bit. idx wraps to 0 on the DONE→IDLE transition.

Optional Feature:
Macro BCD_GRAY_ERR_CHECK_EN.
- Defined:
  - Any digit greater than 9 sets out_err=1 (sticky for that word).
  - That digit's out_gray field is forced to 4'b0000.
  - Valid digits convert normally.
- Undefined:
  - Invalid digits are converted raw by the same formula (e.g. 4'hA→4'b1111).
  - out_err is tied to 0.

Decomposition:
- Shared package/include file bcd_gray_pkg: state localparams (S_IDLE=2'd0, S_CONV=2'd1, S_DONE=2'd2), BCD_MAX=4'd9, DIGIT_W=4.
- Sub-module: one instance of the existing bcd_to_gray (ports bcd[3:0], gray[3:0]) as the shared converter. No other hierarchy.

Test Plan:
All scenarios use DIGITS=4.
1. Basic conversion: in_bcd=16'h1234, out_ready=1 → out_valid rises 4 cycles after acceptance; out_gray=16'h1326, out_err=0; in_ready returns high the cycle after the output handshake.
2. High digits: in_bcd=16'h9870 → out_gray=16'hDC40, out_err=0.
3. Invalid digit: in_bcd=16'h00A5.
   - With BCD_GRAY_ERR_CHECK_EN: out_gray=16'h0007, out_err=1.
   - Without it: out_gray=16'h00F7, out_err=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE and pulse in_valid with 16'h5555 → out_valid, out_gray and out_err stay stable, in_ready=0, the new word is not captured. After out_ready=1, IDLE is reached and then 16'h5555 is accepted → out_gray=16'h7777.
5. Reset mid-operation: assert rst_n=0 during the 2nd CONV cycle of 16'h1234 → all outputs 0 immediately, state IDLE. After release, in_ready=1 and a fresh word 16'h0001 converts to 16'h0001.
